// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store controller between the memory stage and dmem.
// Splits misaligned or unsupported-lane accesses into multi-cycle sequences.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we/req_funct3    store flag and RISC-V funct3
//   req_addr/req_wdata   byte address and right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata/resp_err  load result (0 for stores/errors), illegal funct3
//   mem_we/mem_amp       dmem write enable and byte-lane mask
//   mem_a/mem_wd         dmem address and write data
//   mem_rd               dmem combinational read of word mem_a[11:2]
module lsu_dmem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [3:0]      mem_amp,
  output logic [31:0]     mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_STORE,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] w0_q;
  logic [1:0]      idx_q;
  logic [2:0]      size_q;
  logic            split_q;

  logic            resp_valid_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;
  logic            mem_we_q;
  logic [3:0]      mem_amp_q;
  logic [31:0]     mem_a_q;
  logic [XLEN-1:0] mem_wd_q;

  logic [2:0]      rq_size;
  logic            rq_ill;
  logic            rq_split;
  logic [1:0]      idx_d;
  logic [31:0]     st_a_d;
  logic [7:0]      st_b_d;
  logic            st_more;

  function automatic logic [3:0] onehot(input logic [1:0] o);
    return 4'b0001 << o;
  endfunction

  // dw holds {w1[23:0], w0}; only bytes off..off+size-1 matter.
  function automatic logic [31:0] ld_ext(
    input logic [55:0] dw,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [31:0] s;
    s = dw[{off, 3'b000} +: 32];
    unique case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_comb begin
    unique case (1'b1)
      (req_funct3[1:0] == 2'b00): rq_size = 3'd1;
      (req_funct3[1:0] == 2'b01): rq_size = 3'd2;
      default:                    rq_size = 3'd4;
    endcase
    if (req_we) begin
      rq_ill = (req_funct3 >= 3'b011);
    end else begin
      rq_ill = (req_funct3 == 3'b011) ||
               (req_funct3[2:1] == 2'b11);
    end
    // Odd halfword stores have no matching amp lane pair in dmem.
    rq_split = (({1'b0, req_addr[1:0]} + rq_size) > 3'd4) ||
               (req_we && (rq_size == 3'd2) && req_addr[0]);
  end

  always_comb begin
    idx_d   = idx_q + 2'd1;
    st_a_d  = addr_q + {30'b0, idx_d};
    st_b_d  = wdata_q[{idx_d, 3'b000} +: 8];
    st_more = split_q && (({1'b0, idx_q} + 3'd1) < size_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b0;
      addr_q       <= 32'b0;
      wdata_q      <= '0;
      w0_q         <= '0;
      idx_q        <= 2'b0;
      size_q       <= 3'b0;
      split_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_amp_q    <= 4'b0;
      mem_a_q      <= 32'b0;
      mem_wd_q     <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= 2'b0;
            size_q  <= rq_size;
            split_q <= rq_split;
            if (rq_ill) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!req_we) begin
              state_q <= S_LOAD0;
              mem_a_q <= {req_addr[31:2], 2'b00};
            end else begin
              state_q  <= S_STORE;
              mem_we_q <= 1'b1;
              mem_a_q  <= req_addr;
              if (rq_split) begin
                mem_amp_q <= onehot(req_addr[1:0]);
                mem_wd_q  <= {4{req_wdata[7:0]}};
              end else begin
                unique case (1'b1)
                  (rq_size == 3'd1): begin
                    mem_amp_q <= onehot(req_addr[1:0]);
                    mem_wd_q  <= {4{req_wdata[7:0]}};
                  end
                  (rq_size == 3'd2): begin
                    mem_amp_q <= req_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wd_q  <= {2{req_wdata[15:0]}};
                  end
                  default: begin
                    mem_amp_q <= 4'b1111;
                    mem_wd_q  <= req_wdata;
                  end
                endcase
              end
            end
          end
        end
        S_LOAD0: begin
          w0_q <= mem_rd;
          if (split_q) begin
            state_q <= S_LOAD1;
            mem_a_q <= mem_a_q + 32'd4;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ld_ext({24'b0, mem_rd}, addr_q[1:0], f3_q);
          end
        end
        S_LOAD1: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ld_ext({mem_rd[23:0], w0_q}, addr_q[1:0], f3_q);
        end
        S_STORE: begin
          if (st_more) begin
            idx_q     <= idx_d;
            mem_a_q   <= st_a_d;
            mem_amp_q <= onehot(st_a_d[1:0]);
            mem_wd_q  <= {4{st_b_d}};
          end else begin
            state_q      <= S_RESP;
            mem_we_q     <= 1'b0;
            mem_amp_q    <= 4'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_amp    = mem_amp_q;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;

endmodule
